// File: rtl/cpu_pkg_fwd.sv
// Shared encodings for the EX-stage forwarding and load-use hazard controller:
// forwarding-mux selects, controller FSM states and the hard-wired zero register.
package cpu_pkg_fwd;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } fwd_state_t;

endpackage

// File: rtl/fwd_match.sv
// Producer comparator for one source register: picks the forwarding select and
// flags an EX-slot hit so the caller can detect load-use hazards.
module fwd_match
  import cpu_pkg_fwd::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_v,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_wr,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_wr,
  output logic [1:0]        sel,
  output logic              ex_hit
);

  logic src_nz;
  logic mem_hit;

  always_comb begin
    src_nz  = (src != REG_AW'(REG_ZERO));
    ex_hit  = src_nz && ex_v && ex_wr && (ex_dst == src);
    mem_hit = src_nz && mem_v && mem_wr && (mem_dst == src);
    // EX holds the newer producer, so it takes precedence over MEM.
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-select generator with load-use stall and memory-freeze control.
// Optional saturating statistics counters are enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl
  import cpu_pkg_fwd::*;
#(
  parameter int unsigned REG_AW = 5
`ifdef FWD_HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              mem_busy,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              freeze
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_loaduse_cnt,
  output logic [CNT_W-1:0]  stat_fwd_cnt,
  output logic [CNT_W-1:0]  stat_freeze_cnt
`endif
);

  logic              ex_v;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_wr;
  logic              ex_ld;
  logic              mem_v;
  logic [REG_AW-1:0] mem_dst;
  logic              mem_wr;

  fwd_state_t state;
  fwd_state_t state_nxt;

  logic [1:0] sel_a_c;
  logic [1:0] sel_b_c;
  logic       ex_hit_a;
  logic       ex_hit_b;
  logic       hazard;

  logic       ctl_freeze;
  logic       ctl_stall;
  logic       ctl_bubble;

  fwd_match #(.REG_AW(REG_AW)) u_match_a (
    .src     (id_rs),
    .ex_v    (ex_v),
    .ex_dst  (ex_dst),
    .ex_wr   (ex_wr),
    .mem_v   (mem_v),
    .mem_dst (mem_dst),
    .mem_wr  (mem_wr),
    .sel     (sel_a_c),
    .ex_hit  (ex_hit_a)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_b (
    .src     (id_rt),
    .ex_v    (ex_v),
    .ex_dst  (ex_dst),
    .ex_wr   (ex_wr),
    .mem_v   (mem_v),
    .mem_dst (mem_dst),
    .mem_wr  (mem_wr),
    .sel     (sel_b_c),
    .ex_hit  (ex_hit_b)
  );

  // rt is compared even when the instruction may not read it: conservative stall.
  always_comb begin
    hazard = id_valid && ex_ld && (ex_hit_a || ex_hit_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // MEM_WAIT releases into a cycle that is evaluated exactly like RUN.
  always_comb begin
    state_nxt = ST_RUN;
    unique case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          state_nxt = ST_MEM_WAIT;
        end else if (hazard) begin
          state_nxt = ST_LOAD_STALL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        state_nxt = mem_busy ? ST_MEM_WAIT : ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    ctl_freeze = mem_busy;
    ctl_bubble = 1'b0;
    ctl_stall  = mem_busy;
    if (!mem_busy && (state != ST_LOAD_STALL) && hazard) begin
      ctl_bubble = 1'b1;
      ctl_stall  = 1'b1;
    end
    freeze      = !rst && ctl_freeze;
    stall_if_id = !rst && ctl_stall;
    bubble_ex   = !rst && ctl_bubble;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v         <= 1'b0;
      ex_dst       <= '0;
      ex_wr        <= 1'b0;
      ex_ld        <= 1'b0;
      mem_v        <= 1'b0;
      mem_dst      <= '0;
      mem_wr       <= 1'b0;
      ex_fwd_a_sel <= FWD_RF;
      ex_fwd_b_sel <= FWD_RF;
    end else if (!ctl_freeze) begin
      mem_v   <= ex_v;
      mem_dst <= ex_dst;
      mem_wr  <= ex_wr;
      if (ctl_bubble) begin
        ex_v         <= 1'b0;
        ex_wr        <= 1'b0;
        ex_ld        <= 1'b0;
        ex_fwd_a_sel <= FWD_RF;
        ex_fwd_b_sel <= FWD_RF;
      end else begin
        ex_v         <= id_valid;
        ex_dst       <= id_dst;
        ex_wr        <= id_regwrite;
        ex_ld        <= id_memread;
        ex_fwd_a_sel <= id_valid ? sel_a_c : FWD_RF;
        ex_fwd_b_sel <= id_valid ? sel_b_c : FWD_RF;
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic fwd_event;

  always_comb begin
    fwd_event = !ctl_freeze && !ctl_bubble && id_valid
                && ((sel_a_c != FWD_RF) || (sel_b_c != FWD_RF));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loaduse_cnt <= '0;
      stat_fwd_cnt     <= '0;
      stat_freeze_cnt  <= '0;
    end else begin
      if (ctl_bubble && (stat_loaduse_cnt != '1)) begin
        stat_loaduse_cnt <= stat_loaduse_cnt + CNT_W'(1);
      end
      if (fwd_event && (stat_fwd_cnt != '1)) begin
        stat_fwd_cnt <= stat_fwd_cnt + CNT_W'(1);
      end
      if (ctl_freeze && (stat_freeze_cnt != '1)) begin
        stat_freeze_cnt <= stat_freeze_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed hazard scenarios followed by
// random traffic, checked against a history-based model of in-flight producers.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_dst;
  logic       id_regwrite;
  logic       id_memread;
  logic       mem_busy;
  logic [1:0] ex_fwd_a_sel;
  logic [1:0] ex_fwd_b_sel;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       freeze;

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .mem_busy     (mem_busy),
    .ex_fwd_a_sel (ex_fwd_a_sel),
    .ex_fwd_b_sel (ex_fwd_b_sel),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .freeze       (freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
  } inst_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       frz;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [15:0] cyc;
  } exp_t;

  // Every instruction (or bubble) that has entered EX, oldest first.
  inst_t hist[$];
  exp_t  sb_q[$];
  logic [1:0] cur_sa;
  logic [1:0] cur_sb;
  int unsigned errors;
  int unsigned checks;
  int unsigned cyc;

  function automatic logic writes(inst_t i, logic [4:0] r);
    return (r != 5'd0) && i.v && i.wr && (i.dst == r);
  endfunction

  function automatic logic [1:0] sel_for(logic [4:0] r);
    if (hist.size() >= 1 && writes(hist[hist.size()-1], r)) return 2'b10;
    if (hist.size() >= 2 && writes(hist[hist.size()-2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic load_hit(logic [4:0] r);
    if (hist.size() == 0) return 1'b0;
    return writes(hist[hist.size()-1], r) && hist[hist.size()-1].ld;
  endfunction

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic wr, input logic ld,
                       input logic busy, input logic rr, output logic held);
    exp_t  e;
    inst_t n;
    @(negedge clk);
    rst = rr; id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_regwrite = wr; id_memread = ld; mem_busy = busy;
    e = '0;
    e.cyc = 16'(cyc);
    cyc++;
    held = 1'b0;
    if (rr) begin
      hist.delete();
      cur_sa = 2'b00;
      cur_sb = 2'b00;
    end else if (busy) begin
      e.frz = 1'b1;
      e.stall = 1'b1;
      held = 1'b1;
    end else if (v && (load_hit(rs) || load_hit(rt))) begin
      e.stall = 1'b1;
      e.bubble = 1'b1;
      held = 1'b1;
      hist.push_back('0);
      cur_sa = 2'b00;
      cur_sb = 2'b00;
    end else begin
      cur_sa = v ? sel_for(rs) : 2'b00;
      cur_sb = v ? sel_for(rt) : 2'b00;
      n.v = v; n.dst = dst; n.wr = wr; n.ld = ld;
      hist.push_back(n);
    end
    if (hist.size() > 4) void'(hist.pop_front());
    e.sa = cur_sa;
    e.sb = cur_sb;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] c,
                     input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
    end
  endtask

  // Monitor: comb controls sampled mid-cycle, registered selects after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall_if_id", e.cyc, {1'b0, stall_if_id}, {1'b0, e.stall});
        chk("bubble_ex", e.cyc, {1'b0, bubble_ex}, {1'b0, e.bubble});
        chk("freeze", e.cyc, {1'b0, freeze}, {1'b0, e.frz});
        @(posedge clk);
        #1;
        chk("ex_fwd_a_sel", e.cyc, ex_fwd_a_sel, e.sa);
        chk("ex_fwd_b_sel", e.cyc, ex_fwd_b_sel, e.sb);
      end
    end
  end

  initial begin
    logic h;
    logic [4:0] rs, rt, dst;
    logic v, wr, ld;
    errors = 0; checks = 0; cyc = 0;
    cur_sa = 2'b00; cur_sb = 2'b00;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; mem_busy = 1'b0;

    issue(0, 0, 0, 0, 0, 0, 0, 1, h);
    issue(0, 0, 0, 0, 0, 0, 0, 1, h);
    // back-to-back ALU forwarding, then MEM-distance forwarding on rt
    issue(1, 1, 2, 8, 1, 0, 0, 0, h);
    issue(1, 8, 3, 10, 1, 0, 0, 0, h);
    issue(1, 4, 8, 11, 1, 0, 0, 0, h);
    // load-use: one stall, then WB-distance select
    issue(1, 1, 0, 9, 1, 1, 0, 0, h);
    issue(1, 9, 2, 12, 1, 0, 0, 0, h);
    issue(1, 9, 2, 12, 1, 0, 0, 0, h);
    // register $0 never matches
    issue(1, 1, 1, 0, 1, 0, 0, 0, h);
    issue(1, 0, 0, 13, 1, 0, 0, 0, h);
    issue(1, 1, 1, 0, 1, 1, 0, 0, h);
    issue(1, 0, 0, 13, 1, 0, 0, 0, h);
    // two producers of r5: newest wins
    issue(1, 1, 2, 5, 1, 0, 0, 0, h);
    issue(1, 1, 2, 5, 1, 0, 0, 0, h);
    issue(1, 5, 5, 14, 1, 0, 0, 0, h);
    // three-cycle freeze mid-stream
    issue(1, 1, 2, 6, 1, 0, 0, 0, h);
    for (int i = 0; i < 3; i++) issue(1, 6, 0, 15, 1, 0, 1, 0, h);
    issue(1, 6, 0, 15, 1, 0, 0, 0, h);
    // freeze and load-use together: freeze first, stall after release
    issue(1, 1, 0, 7, 1, 1, 0, 0, h);
    issue(1, 2, 7, 16, 1, 0, 1, 0, h);
    issue(1, 2, 7, 16, 1, 0, 0, 0, h);
    issue(1, 2, 7, 16, 1, 0, 0, 0, h);
    // reset while in the load stall discards the pending hazard
    issue(1, 1, 0, 9, 1, 1, 0, 0, h);
    issue(1, 9, 0, 17, 1, 0, 0, 0, h);
    issue(1, 9, 0, 17, 1, 0, 0, 1, h);
    issue(1, 9, 0, 17, 1, 0, 0, 0, h);

    h = 1'b0;
    v = 1'b0; rs = '0; rt = '0; dst = '0; wr = 1'b0; ld = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!h) begin
        v   = ($urandom_range(0, 9) != 0);
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        dst = 5'($urandom_range(0, 3));
        wr  = ($urandom_range(0, 9) < 7);
        ld  = wr && ($urandom_range(0, 3) == 0);
      end
      issue(v, rs, rt, dst, wr, ld, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 39) == 0), h);
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
